// File: rtl/cycle_timing_generator.sv
// One-hot T-step / M-cycle sequencer feeding the instruction microcode decoders.
// Handles wait freezing, halt parking, the boot fetch after reset and a sticky overrun flag.
module cycle_timing_generator (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Wait,
  input  logic       i_Halt,
  input  logic       i_IR_Fetch,
  output logic [3:0] o_Cycle_Step,
  output logic [7:0] o_Cycle_Count,
  output logic [2:0] o_Cycle_Index,
  output logic       o_M_Boundary,
  output logic       o_Instruction_Start,
  output logic       o_Boot_Fetch,
  output logic       o_Halted,
  output logic       o_Overrun
);

  logic [3:0] step_nxt;
  logic [7:0] count_nxt;
  logic [2:0] index_nxt;
  logic       start_nxt;
  logic       boot_nxt;
  logic       halted_nxt;
  logic       overrun_nxt;

  assign o_M_Boundary = o_Cycle_Step[3] & ~i_Wait;

  always_comb begin
    step_nxt    = o_Cycle_Step;
    count_nxt   = o_Cycle_Count;
    index_nxt   = o_Cycle_Index;
    start_nxt   = o_Instruction_Start;
    boot_nxt    = o_Boot_Fetch;
    halted_nxt  = o_Halted;
    overrun_nxt = o_Overrun;
    if (!i_Wait) begin
      step_nxt  = {o_Cycle_Step[2:0], o_Cycle_Step[3]};
      start_nxt = 1'b0;
      if (o_M_Boundary) begin
        boot_nxt = 1'b0;
        // While parked, every boundary restarts M-cycle 0 regardless of the fetch request.
        if (i_IR_Fetch || o_Boot_Fetch || o_Halted) begin
          count_nxt  = 8'h01;
          index_nxt  = 3'd0;
          halted_nxt = i_Halt;
          start_nxt  = ~i_Halt;
        end else if (o_Cycle_Count[7]) begin
          overrun_nxt = 1'b1;
        end else begin
          count_nxt = {o_Cycle_Count[6:0], 1'b0};
          index_nxt = o_Cycle_Index + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      o_Cycle_Step        <= 4'b0001;
      o_Cycle_Count       <= 8'h01;
      o_Cycle_Index       <= 3'd0;
      o_Instruction_Start <= 1'b0;
      o_Boot_Fetch        <= 1'b1;
      o_Halted            <= 1'b0;
      o_Overrun           <= 1'b0;
    end else begin
      o_Cycle_Step        <= step_nxt;
      o_Cycle_Count       <= count_nxt;
      o_Cycle_Index       <= index_nxt;
      o_Instruction_Start <= start_nxt;
      o_Boot_Fetch        <= boot_nxt;
      o_Halted            <= halted_nxt;
      o_Overrun           <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_cycle_timing_generator.sv
// Directed self-checking bench for cycle_timing_generator.
// Inputs change and outputs are sampled on the falling edge; clock k = k-th rising edge after reset release.
module tb_cycle_timing_generator;

  logic       clk;
  logic       rst_n;
  logic       wait_in;
  logic       halt;
  logic       ir_fetch;
  logic [3:0] step;
  logic [7:0] count;
  logic [2:0] index;
  logic       m_boundary;
  logic       inst_start;
  logic       boot;
  logic       halted;
  logic       overrun;

  logic       fetch_force;
  logic       fetch_en;
  logic [2:0] fetch_bit;

  int checks = 0;
  int passed = 0;

  // Decoder stand-in: fetch is a combinational function of the M-cycle count.
  assign ir_fetch = fetch_force | (fetch_en & count[fetch_bit]);

  cycle_timing_generator dut (
    .i_Clk               (clk),
    .i_Reset_n           (rst_n),
    .i_Wait              (wait_in),
    .i_Halt              (halt),
    .i_IR_Fetch          (ir_fetch),
    .o_Cycle_Step        (step),
    .o_Cycle_Count       (count),
    .o_Cycle_Index       (index),
    .o_M_Boundary        (m_boundary),
    .o_Instruction_Start (inst_start),
    .o_Boot_Fetch        (boot),
    .o_Halted            (halted),
    .o_Overrun           (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst_n = 1'b0; wait_in = 1'b0; halt = 1'b0;
    fetch_force = 1'b0; fetch_en = 1'b0; fetch_bit = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({step, count, index, boot, halted, overrun, inst_start, m_boundary} !==
        {4'b0001, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state got step=%b count=%h idx=%0d boot=%b halt=%b ovr=%b start=%b mb=%b",
               step, count, index, boot, halted, overrun, inst_start, m_boundary);
    end else passed++;
  endtask

  task automatic test_free_run();
    logic [3:0] es;
    logic [7:0] ec;
    int         ei;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      es = 4'b0001 << (i % 4);
      ei = (i < 8) ? 0 : ((i / 4 - 1) > 7 ? 7 : i / 4 - 1);
      ec = 8'h01 << ei;
      checks++;
      if ({step, count, index, boot, overrun, inst_start} !==
          {es, ec, 3'(ei), (i < 4), (i >= 36), (i == 4)}) begin
        $display("FAIL free_run clk=%0d got step=%b count=%h idx=%0d boot=%b ovr=%b start=%b exp step=%b count=%h idx=%0d boot=%b ovr=%b start=%b",
                 i, step, count, index, boot, overrun, inst_start,
                 es, ec, ei, (i < 4), (i >= 36), (i == 4));
      end else passed++;
    end
    // A fetch after overrun restarts sequencing but the flag stays set.
    fetch_force = 1'b1;
    repeat (4) @(negedge clk);
    fetch_force = 1'b0;
    checks++;
    if ({count, index, inst_start, overrun} !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
      $display("FAIL overrun_refetch got count=%h idx=%0d start=%b ovr=%b exp count=01 idx=0 start=1 ovr=1",
               count, index, inst_start, overrun);
    end else passed++;
    rst_n = 1'b0; wait_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; wait_in = 1'b0;
    checks++;
    if ({overrun, boot, count} !== {1'b0, 1'b1, 8'h01}) begin
      $display("FAIL overrun_clear got ovr=%b boot=%b count=%h exp ovr=0 boot=1 count=01",
               overrun, boot, count);
    end else passed++;
  endtask

  task automatic test_call();
    logic [7:0] ec;
    logic       est;
    do_reset();
    fetch_en = 1'b1; fetch_bit = 3'd5;
    for (int i = 1; i <= 56; i++) begin
      @(negedge clk);
      ec  = (i < 4) ? 8'h01 : (8'h01 << (((i - 4) / 4) % 6));
      est = (i >= 4) && ((i - 4) % 24 == 0);
      checks++;
      if ({count, inst_start, overrun} !== {ec, est, 1'b0}) begin
        $display("FAIL call6 clk=%0d got count=%h start=%b ovr=%b exp count=%h start=%b ovr=0",
                 i, count, inst_start, overrun, ec, est);
      end else passed++;
    end
  endtask

  task automatic test_cond_false();
    logic [7:0] ec;
    logic       est;
    do_reset();
    fetch_en = 1'b1; fetch_bit = 3'd2;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      ec  = (i < 4) ? 8'h01 : (8'h01 << (((i - 4) / 4) % 3));
      est = (i >= 4) && ((i - 4) % 12 == 0);
      checks++;
      if ({count, inst_start} !== {ec, est}) begin
        $display("FAIL call_short clk=%0d got count=%h start=%b exp count=%h start=%b",
                 i, count, inst_start, ec, est);
      end else passed++;
    end
  endtask

  task automatic test_wait();
    do_reset();
    fetch_en = 1'b1; fetch_bit = 3'd2;
    repeat (2) @(negedge clk);
    wait_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({step, count, boot, m_boundary} !== {4'b0100, 8'h01, 1'b1, 1'b0}) begin
        $display("FAIL wait_freeze n=%0d got step=%b count=%h boot=%b mb=%b exp step=0100 count=01 boot=1 mb=0",
                 i, step, count, boot, m_boundary);
      end else passed++;
    end
    wait_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({step, m_boundary} !== {4'b1000, 1'b1}) begin
      $display("FAIL wait_late_boundary got step=%b mb=%b exp step=1000 mb=1", step, m_boundary);
    end else passed++;
    wait_in = 1'b1;
    #1;
    checks++;
    if (m_boundary !== 1'b0) begin
      $display("FAIL wait_blocks_boundary got mb=%b exp 0", m_boundary);
    end else passed++;
    @(negedge clk);
    wait_in = 1'b0;
    checks++;
    if ({step, count, boot, inst_start} !== {4'b1000, 8'h01, 1'b1, 1'b0}) begin
      $display("FAIL wait_step3_hold got step=%b count=%h boot=%b start=%b exp step=1000 count=01 boot=1 start=0",
               step, count, boot, inst_start);
    end else passed++;
    @(negedge clk);
    checks++;
    if ({step, count, boot, inst_start} !== {4'b0001, 8'h01, 1'b0, 1'b1}) begin
      $display("FAIL wait_boot_fetch got step=%b count=%h boot=%b start=%b exp step=0001 count=01 boot=0 start=1",
               step, count, boot, inst_start);
    end else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if ({step, count, index, inst_start} !== {4'b0001, 8'h02, 3'd1, 1'b0}) begin
      $display("FAIL wait_resume got step=%b count=%h idx=%0d start=%b exp step=0001 count=02 idx=1 start=0",
               step, count, index, inst_start);
    end else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    fetch_force = 1'b1; halt = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({count, halted, inst_start} !== {8'h01, (i >= 4), 1'b0}) begin
        $display("FAIL halt_park clk=%0d got count=%h halted=%b start=%b exp count=01 halted=%b start=0",
                 i, count, halted, inst_start, (i >= 4));
      end else passed++;
    end
    halt = 1'b0; fetch_force = 1'b0;
    for (int i = 13; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({count, halted, inst_start} !== {(i < 20) ? 8'h01 : 8'h02, (i < 16), (i == 16)}) begin
        $display("FAIL halt_release clk=%0d got count=%h halted=%b start=%b exp count=%h halted=%b start=%b",
                 i, count, halted, inst_start, (i < 20) ? 8'h01 : 8'h02, (i < 16), (i == 16));
      end else passed++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (21) @(negedge clk);
    checks++;
    if ({step, count, index} !== {4'b0010, 8'h10, 3'd4}) begin
      $display("FAIL mid_setup got step=%b count=%h idx=%0d exp step=0010 count=10 idx=4", step, count, index);
    end else passed++;
    rst_n = 1'b0; wait_in = 1'b1; halt = 1'b1; fetch_force = 1'b1;
    @(negedge clk);
    checks++;
    if ({step, count, index, boot, overrun, halted, inst_start} !==
        {4'b0001, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL mid_reset got step=%b count=%h idx=%0d boot=%b ovr=%b halted=%b start=%b exp step=0001 count=01 idx=0 boot=1 ovr=0 halted=0 start=0",
               step, count, index, boot, overrun, halted, inst_start);
    end else passed++;
    rst_n = 1'b1; wait_in = 1'b0; halt = 1'b0; fetch_force = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wait_in = 1'b0; halt = 1'b0;
    fetch_force = 1'b0; fetch_en = 1'b0; fetch_bit = 3'd0;
    test_reset();
    test_free_run();
    test_call();
    test_cond_false();
    test_wait();
    test_halt();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
